// File: rtl/saw_receiver_pkg.sv
// Shared definitions for the Stop-and-Wait ARQ link (sender and receiver).
// Contents: frame geometry, CRC-4 polynomial, receiver state codes and
// the ACK/NAK encoding.
package saw_pkg;

  localparam int unsigned DW   = 5;             // payload width
  localparam int unsigned CW   = 4;             // CRC width
  localparam int unsigned BW   = 1 + DW + CW;   // frame = {seq, data, crc}
  localparam int unsigned CNTW = $clog2(BW);    // bit counter, holds 0..BW

  // x^4 + x + 1 with the x^4 term implied
  localparam logic [CW-1:0] CRC_POLY = 4'b0011;

  // Receiver FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  // Response encoding on ack_nak
  localparam logic RESP_ACK = 1'b0;
  localparam logic RESP_NAK = 1'b1;

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 LFSR (x^4+x+1), shared by the sender and the receiver.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_clr         synchronous clear of the remainder (wins over i_en)
//   i_en          shift one bit in
//   i_bit         serial input bit, MSB of the message first
//   o_rem         current remainder
module crc4_serial
  import saw_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_bit,
  output logic [CW-1:0] o_rem
);

  logic [CW-1:0] r_rem;
  logic          w_fb;

  assign w_fb  = r_rem[CW-1] ^ i_bit;
  assign o_rem = r_rem;

  // LFSR step: shift left, fold the polynomial in when the feedback is set
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem <= '0;
    end else if (i_clr) begin
      r_rem <= '0;
    end else if (i_en) begin
      r_rem <= {r_rem[CW-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/saw_receiver.sv
// Stop-and-Wait ARQ receiver: accepts one frame, checks CRC-4 bit-serially,
// filters duplicates by the alternating sequence bit, delivers new payloads
// once, and returns exactly one ACK/NAK per accepted frame.
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_frame_valid/i_frame_data      frame from channel; o_frame_ready in IDLE
//   o_out_valid/o_out_data          payload to sink; i_out_ready handshake
//   o_ack_valid/o_ack_nak/o_ack_seq response to sender; i_ack_ready handshake
//   o_expected_seq                  next in-order sequence number
//   o_crc_err_cnt                   saturating count of CRC failures
module saw_receiver
  import saw_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_valid,
  input  logic [BW-1:0] i_frame_data,
  output logic          o_frame_ready,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  input  logic          i_out_ready,
  output logic          o_ack_valid,
  output logic          o_ack_nak,
  output logic          o_ack_seq,
  input  logic          i_ack_ready,
  output logic          o_expected_seq,
  output logic [7:0]    o_crc_err_cnt
);

  localparam logic [CNTW-1:0] CNT_DONE = CNTW'(BW);

  logic [1:0]      r_state,       w_state_nxt;
  logic [BW-1:0]   r_frame,       w_frame_nxt;
  logic [CNTW-1:0] r_cnt,         w_cnt_nxt;
  logic            r_frame_ready, w_frame_ready_nxt;
  logic            r_out_valid,   w_out_valid_nxt;
  logic [DW-1:0]   r_out_data,    w_out_data_nxt;
  logic            r_ack_valid,   w_ack_valid_nxt;
  logic            r_ack_nak,     w_ack_nak_nxt;
  logic            r_ack_seq,     w_ack_seq_nxt;
  logic            r_exp_seq,     w_exp_seq_nxt;
  logic [7:0]      r_err_cnt,     w_err_cnt_nxt;

  logic            w_crc_clr;
  logic            w_crc_en;
  logic [BW-1:0]   w_shifted;
  logic [CW-1:0]   w_rem;

  // Current serial bit: frame shifted so bit r_cnt (from MSB) sits on top
  assign w_shifted = r_frame << r_cnt;

  crc4_serial u_crc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_bit (w_shifted[BW-1]),
    .o_rem (w_rem)
  );

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_frame       <= '0;
      r_cnt         <= '0;
      r_frame_ready <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_ack_valid   <= 1'b0;
      r_ack_nak     <= RESP_ACK;
      r_ack_seq     <= 1'b0;
      r_exp_seq     <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame       <= w_frame_nxt;
      r_cnt         <= w_cnt_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_data    <= w_out_data_nxt;
      r_ack_valid   <= w_ack_valid_nxt;
      r_ack_nak     <= w_ack_nak_nxt;
      r_ack_seq     <= w_ack_seq_nxt;
      r_exp_seq     <= w_exp_seq_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_frame_nxt       = r_frame;
    w_cnt_nxt         = r_cnt;
    w_frame_ready_nxt = r_frame_ready;
    w_out_valid_nxt   = r_out_valid;
    w_out_data_nxt    = r_out_data;
    w_ack_valid_nxt   = r_ack_valid;
    w_ack_nak_nxt     = r_ack_nak;
    w_ack_seq_nxt     = r_ack_seq;
    w_exp_seq_nxt     = r_exp_seq;
    w_err_cnt_nxt     = r_err_cnt;
    w_crc_clr         = 1'b0;
    w_crc_en          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_frame_valid && r_frame_ready) begin
          w_frame_nxt       = i_frame_data;
          w_cnt_nxt         = '0;
          w_crc_clr         = 1'b1;
          w_frame_ready_nxt = 1'b0;
          w_state_nxt       = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (r_cnt != CNT_DONE) begin
          w_crc_en  = 1'b1;
          w_cnt_nxt = r_cnt + CNTW'(1);
        end else if (w_rem != '0) begin
          // Corrupted frame: NAK against the sequence we are waiting for
          w_ack_valid_nxt = 1'b1;
          w_ack_nak_nxt   = RESP_NAK;
          w_ack_seq_nxt   = r_exp_seq;
          w_err_cnt_nxt   = (r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
          w_state_nxt     = ST_RESP;
        end else if (r_frame[BW-1] == r_exp_seq) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = r_frame[BW-2:CW];
          w_state_nxt     = ST_DELIVER;
        end else begin
          // Duplicate after a lost ACK: re-acknowledge, drop the payload
          w_ack_valid_nxt = 1'b1;
          w_ack_nak_nxt   = RESP_ACK;
          w_ack_seq_nxt   = r_frame[BW-1];
          w_state_nxt     = ST_RESP;
        end
      end

      ST_DELIVER: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_exp_seq_nxt   = ~r_exp_seq;
          w_ack_valid_nxt = 1'b1;
          w_ack_nak_nxt   = RESP_ACK;
          w_ack_seq_nxt   = r_frame[BW-1];
          w_state_nxt     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (i_ack_ready) begin
          w_ack_valid_nxt   = 1'b0;
          w_frame_ready_nxt = 1'b1;
          w_state_nxt       = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_frame_ready_nxt = 1'b1;
        w_out_valid_nxt   = 1'b0;
        w_ack_valid_nxt   = 1'b0;
      end
    endcase
  end

  assign o_frame_ready  = r_frame_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_ack_valid    = r_ack_valid;
  assign o_ack_nak      = r_ack_nak;
  assign o_ack_seq      = r_ack_seq;
  assign o_expected_seq = r_exp_seq;
  assign o_crc_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_saw_receiver.sv
// Bench for saw_receiver: transaction-level reference model compared every
// cycle, plus directed frames with hand-computed expectations.
module tb_saw_receiver;
  import saw_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_valid;
  logic [BW-1:0] frame_data;
  logic          frame_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ack_valid;
  logic          ack_nak;
  logic          ack_seq;
  logic          ack_ready;
  logic          expected_seq;
  logic [7:0]    crc_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  saw_receiver dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_frame_valid  (frame_valid),
    .i_frame_data   (frame_data),
    .o_frame_ready  (frame_ready),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .i_out_ready    (out_ready),
    .o_ack_valid    (ack_valid),
    .o_ack_nak      (ack_nak),
    .o_ack_seq      (ack_seq),
    .i_ack_ready    (ack_ready),
    .o_expected_seq (expected_seq),
    .o_crc_err_cnt  (crc_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame is good iff its polynomial is divisible by x^4+x+1 (long division)
  function automatic bit crc_good(input logic [BW-1:0] f);
    logic [BW-1:0] r;
    logic [BW-1:0] gen;
    r   = f;
    gen = 10'b00_0001_0011;
    for (int i = BW - 1; i >= CW; i--)
      if (r[i]) r = r ^ (gen << (i - CW));
    return (r[CW-1:0] == '0);
  endfunction

  // Transaction-level model of the expected outputs
  bit            m_fr = 1'b1, m_ov = 1'b0, m_av = 1'b0;
  bit            m_nak = 1'b0, m_seq = 1'b0, m_exp = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_err = 0;
  logic [BW-1:0] m_frame = '0;
  int            m_wait = 0;   // cycles until the verdict on the held frame

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fr = 1'b1; m_ov = 1'b0; m_av = 1'b0; m_nak = 1'b0; m_seq = 1'b0;
      m_exp = 1'b0; m_data = '0; m_err = 0; m_frame = '0; m_wait = 0;
    end else if (m_fr && frame_valid) begin
      m_frame = frame_data;
      m_fr    = 1'b0;
      m_wait  = BW + 1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        if (!crc_good(m_frame)) begin
          m_av = 1'b1; m_nak = 1'b1; m_seq = m_exp;
          if (m_err < 255) m_err++;
        end else if (m_frame[BW-1] == m_exp) begin
          m_ov = 1'b1; m_data = m_frame[BW-2:CW];
        end else begin
          m_av = 1'b1; m_nak = 1'b0; m_seq = m_frame[BW-1];
        end
      end
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0; m_exp = ~m_exp;
      m_av = 1'b1; m_nak = 1'b0; m_seq = m_frame[BW-1];
    end else if (m_av && ack_ready) begin
      m_av = 1'b0; m_fr = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cmp_frame_ready", frame_ready, m_fr);
      chk("cmp_out_valid", out_valid, m_ov);
      chk("cmp_out_data", out_data, m_data);
      chk("cmp_ack_valid", ack_valid, m_av);
      chk("cmp_ack_nak", ack_nak, m_nak);
      chk("cmp_ack_seq", ack_seq, m_seq);
      chk("cmp_expected_seq", expected_seq, m_exp);
      chk("cmp_crc_err_cnt", crc_err_cnt, 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (frame_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk(name, (k < 200), 1'b1);
  endtask

  // Present a frame for one cycle; returns 1ns after the accept edge T
  task automatic send(input logic [BW-1:0] f);
    wait_ready("ready_timeout");
    frame_valid = 1'b1;
    frame_data  = f;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_frame_ready"}, frame_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 5'd0);
    chk({tag, "_ack_valid"}, ack_valid, 1'b0);
    chk({tag, "_ack_nak"}, ack_nak, 1'b0);
    chk({tag, "_ack_seq"}, ack_seq, 1'b0);
    chk({tag, "_expected_seq"}, expected_seq, 1'b0);
    chk({tag, "_crc_err_cnt"}, crc_err_cnt, 8'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_valid = 1'b0; frame_data = '0;
    out_ready = 1'b1; ack_ready = 1'b1;

    // Pin the reference CRC check with hand-computed frames
    chk("model_16F_good", crc_good(10'h16F), 1'b1);
    chk("model_16E_bad", crc_good(10'h16E), 1'b0);
    chk("model_365_good", crc_good(10'h365), 1'b1);
    chk("model_20A_good", crc_good(10'h20A), 1'b1);

    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Single-bit error while expecting seq 0: NAK seq 0 at T+11
    send(10'h16E);
    repeat (10) tick();
    chk("nak_early_ack_valid", ack_valid, 1'b0);
    tick();
    chk("nak_ack_valid", ack_valid, 1'b1);
    chk("nak_ack_nak", ack_nak, 1'b1);
    chk("nak_ack_seq", ack_seq, 1'b0);
    chk("nak_err_cnt", crc_err_cnt, 8'd1);
    chk("nak_out_valid", out_valid, 1'b0);
    tick();
    chk("nak_back_idle", frame_ready, 1'b1);

    // Good frame 0x16F: deliver at T+11, ACK at T+12, ready at T+13
    send(10'h16F);
    repeat (10) tick();
    chk("good_early_out_valid", out_valid, 1'b0);
    tick();
    chk("good_out_valid", out_valid, 1'b1);
    chk("good_out_data", out_data, 5'b10110);
    chk("good_ack_valid_t11", ack_valid, 1'b0);
    tick();
    chk("good_ack_valid", ack_valid, 1'b1);
    chk("good_ack_nak", ack_nak, 1'b0);
    chk("good_ack_seq", ack_seq, 1'b0);
    chk("good_expected_seq", expected_seq, 1'b1);
    chk("good_out_valid_drop", out_valid, 1'b0);
    tick();
    chk("good_frame_ready_t13", frame_ready, 1'b1);

    // Duplicate 0x16F: ACK seq 0, no delivery, counters unchanged
    send(10'h16F);
    repeat (11) tick();
    chk("dup_out_valid", out_valid, 1'b0);
    chk("dup_ack_valid", ack_valid, 1'b1);
    chk("dup_ack_nak", ack_nak, 1'b0);
    chk("dup_ack_seq", ack_seq, 1'b0);
    chk("dup_expected_seq", expected_seq, 1'b1);
    chk("dup_err_cnt", crc_err_cnt, 8'd1);

    // Backpressure on both handshakes with good seq-1 frame 0x365
    out_ready = 1'b0;
    send(10'h365);
    repeat (11) tick();
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_out_data", out_data, 5'b10110);
    for (int i = 0; i < 5; i++) begin
      frame_valid = 1'b1;
      frame_data  = 10'h16E;
      tick();
      chk("bp_hold_out_valid", out_valid, 1'b1);
      chk("bp_hold_out_data", out_data, 5'b10110);
      chk("bp_hold_frame_ready", frame_ready, 1'b0);
      chk("bp_hold_ack_valid", ack_valid, 1'b0);
    end
    frame_valid = 1'b0;
    out_ready = 1'b1;
    ack_ready = 1'b0;
    tick();
    chk("bp_ack_after_release", ack_valid, 1'b1);
    chk("bp_ack_seq", ack_seq, 1'b1);
    chk("bp_out_valid_drop", out_valid, 1'b0);
    chk("bp_expected_seq", expected_seq, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ack_held", ack_valid, 1'b1);
    end
    ack_ready = 1'b1;
    tick();
    chk("bp_ack_done", ack_valid, 1'b0);
    chk("bp_ready_back", frame_ready, 1'b1);

    // Reset during CHECK bit 4: everything back to reset, no response
    send(10'h16F);
    repeat (4) tick();
    rst = 1'b1;
    #1 chk_reset_vals("midrst");
    tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("midrst_no_ack", ack_valid, 1'b0);
    chk("midrst_no_out", out_valid, 1'b0);
    chk("midrst_exp_seq", expected_seq, 1'b0);

    // Corrupted frames: error counter saturates at 255
    for (int i = 0; i < 255; i++) send(10'h16E);
    wait_ready("sat_wait");
    chk("sat_err_255", crc_err_cnt, 8'd255);
    for (int i = 0; i < 5; i++) send(10'h16E);
    wait_ready("sat_wait2");
    chk("sat_err_hold", crc_err_cnt, 8'd255);
    chk("sat_exp_seq", expected_seq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/saw_receiver.md
# saw_receiver

Receiving end of the Stop-and-Wait ARQ link. Accepts one framed word at a time from the channel, checks the frame bit-serially against CRC-4, and enforces the 1-bit alternating sequence number. It delivers each new frame's payload exactly once downstream and returns an ACK or NAK to the sender FSM. It sits between the channel model and the sink, mirroring the sender's frame build / timer path.

## Interface
Parameters:
- DW, 5, payload width
- CW, 4, CRC width (fixed polynomial x^4+x+1)
- BW, 1+DW+CW = 10, frame width; frame = {seq[BW-1], data[BW-2:CW], crc[CW-1:0]}

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- frame_valid  in  1  channel presents a frame
- frame_data  in  BW  frame word
- frame_ready  out  1  receiver can accept; high only in IDLE
- out_valid  out  1  payload available to sink
- out_data  out  DW  payload
- out_ready  in  1  sink accepts payload
- ack_valid  out  1  response to sender pending
- ack_nak  out  1  0 = ACK, 1 = NAK
- ack_seq  out  1  sequence number carried by the response
- ack_ready  in  1  sender accepts response
- expected_seq  out  1  next in-order sequence number
- crc_err_cnt  out  8  count of CRC-failed frames, saturating at 255

## Operation
- States: IDLE, CHECK, DELIVER, RESP.
- IDLE: frame_ready=1. On frame_valid&frame_ready, latch frame_data into frame_t, clear CRC register and bit counter, go to CHECK.
- CHECK: consume one bit of frame_t per cycle, MSB first, all BW bits.
  - Update: fb = r[3]^bit; r <= {r[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - The frame is good iff r==0 after the last bit.
  - The sender's crc field equals r after feeding only {seq,data} from r=0.
- After the last CHECK cycle, branch as follows:
  - Bad CRC: ack_nak=1, ack_seq=expected_seq; crc_err_cnt+1, saturating; go to RESP.
  - Good, seq==expected_seq: go to DELIVER.
  - Good, seq!=expected_seq: this is a duplicate caused by a lost ACK. Discard the payload; ack_nak=0, ack_seq=frame seq; go to RESP.
- DELIVER: out_valid=1, out_data=frame data, both held stable until out_ready. On handshake, toggle expected_seq, set ack_nak=0, ack_seq=frame seq, go to RESP.
- RESP: ack_valid=1 with ack_nak/ack_seq held stable until ack_ready. On handshake, go to IDLE.
- frame_valid outside IDLE is ignored: no capture, no state effect.
- Responses are never dropped or merged. Exactly one response per accepted frame.

## Timing
- Reset values:
  - state=IDLE, frame_ready=1
  - out_valid=0, out_data=0
  - ack_valid=0, ack_nak=0, ack_seq=0
  - expected_seq=0, crc_err_cnt=0
  - frame_t=0, CRC register=0
- Accept at edge T.
  - CHECK occupies cycles T+1..T+BW.
  - out_valid (good new frame) or ack_valid (bad/duplicate frame) rises at T+BW+1.
- Good frame, out_ready tied high: ack_valid at T+BW+2.
- Zero-wait path: ack_ready high gives frame_ready at T+BW+3. Next accept is possible that cycle.
- All outputs are registered; no combinational in→out paths.
- expected_seq changes on the DELIVER handshake edge only. crc_err_cnt changes on the CHECK→RESP edge only.
- rst mid-frame (any state) returns all state to reset values immediately. The partially checked frame is lost and no response is issued.

## Structure
- Shared package saw_pkg holds:
  - DW, CW, BW
  - CRC_POLY = 4'b0011
  - state enum {IDLE, CHECK, DELIVER, RESP}
  - ACK/NAK encoding constants
- The sender side also imports saw_pkg.
- One sub-module, crc4_serial: bit-serial LFSR with clr, en, bit_in, and 4-bit rem output. It is reusable by the sender for CRC generation.
- The bit counter is $clog2(BW) wide and lives in saw_receiver.

## Test plan
- Reset, then frame 0x16F (seq=0, data=10110, crc=1111) with out_ready=ack_ready=1:
  - out_valid with out_data=5'b10110 at T+11
  - ACK, ack_seq=0 at T+12
  - expected_seq=1
- Resend 0x16F after the above:
  - no out_valid
  - ACK with ack_seq=0
  - expected_seq stays 1
  - crc_err_cnt stays 0
- Frame 0x16E (single-bit error), with expected_seq=0:
  - NAK, ack_seq=0
  - crc_err_cnt=1
  - no out_valid
- Backpressure:
  - Hold out_ready=0 for 5 cycles: out_valid/out_data stay stable and frame_valid pulses are ignored.
  - Release out_ready: ACK follows next cycle.
  - Hold ack_ready=0 for 3 cycles: ack_valid stays high.
- Assert rst during CHECK bit 4:
  - all outputs return to reset values
  - no ack_valid
  - expected_seq=0
- 256+ corrupted frames: crc_err_cnt saturates at 255.
